cpu_state_dumper: RTL and testbench

Debug readout engine for the single-cycle CPU. On a start pulse it snapshots the CPU PC and walks the CPU's display ports: register file r0..r31 via rf_addr/rf_data, then data memory words 0..31 via mem_addr/mem_data. It serialises the snapshot as a fixed 261-byte frame on a UART 8N1 transmit line. It is the reader at the other end of the CPU's display interface: it drives the address inputs and consumes the data outputs.

---
 rtl/cpu_state_dumper.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_state_dumper.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper
// Debug readout engine for the single-cycle CPU. A start request snapshots the
// PC, then walks the register file (r0..r31) and data memory words 0..31 via
// the CPU display ports. The snapshot goes out as one 261-byte UART 8N1 frame:
// header 0xA5, PC, r0..r31, mem[0..31], each word MSB first, no inter-byte gap.
module cpu_state_dumper #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_WORD,
    S_DONE
  } state_t;

  // Bit sub-counter spans 0..CLKS_PER_BIT-1; one bit is enough when CLKS_PER_BIT=2.
  localparam int unsigned          BIT_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]           BIT_IDX_LAST  = 4'd9;   // stop bit
  localparam logic [1:0]           BYTE_IDX_LAST = 2'd3;
  localparam logic [6:0]           WORD_IDX_LAST = 7'd64;
  // Words 0..31 are followed by a register word; words 32..63 by a memory word.
  localparam logic [6:0]           LAST_PRE_RF   = 7'd31;
  localparam logic [4:0]           IDX_LAST      = 5'd31;
  localparam logic [7:0]           HEADER        = 8'hA5;

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [6:0]             word_idx_q, word_idx_d;
  logic [31:0]            word_buf_q, word_buf_d;
  logic [4:0]             rf_addr_q, rf_addr_d;
  logic [4:0]             mem_idx_q, mem_idx_d;
  logic                   tx_q, tx_d;

  logic                   bit_end;
  logic                   byte_end;
  logic                   word_end;
  logic [BIT_CNT_W-1:0]   bit_cnt_adv;
  logic [3:0]             bit_idx_adv;
  logic [7:0]             cur_byte;
  logic [2:0]             data_sel;

  // Terminal-count decodes: every wrap is an explicit compare, never an overflow.
  assign bit_end  = (bit_cnt_q == BIT_CNT_LAST);
  assign byte_end = bit_end && (bit_idx_q == BIT_IDX_LAST);
  assign word_end = byte_end && (byte_idx_q == BYTE_IDX_LAST);

  // Selects one byte of a word, byte 0 being the most significant.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Bit-time and bit-index advance shared by the HDR and WORD states.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bit_cnt_adv = bit_cnt_q;
    bit_idx_adv = bit_idx_q;
    if (bit_end) begin
      bit_cnt_adv = '0;
      bit_idx_adv = (bit_idx_q == BIT_IDX_LAST) ? 4'd0 : bit_idx_q + 4'd1;
    end else begin
      bit_cnt_adv = bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  // Next-state logic: frame sequencing, word capture and display-address walk.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    word_buf_d = word_buf_q;
    rf_addr_d  = rf_addr_q;
    mem_idx_d  = mem_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          word_buf_d = cpu_pc;
          rf_addr_d  = '0;
          mem_idx_d  = '0;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
        end
      end

      S_HDR: begin
        bit_cnt_d = bit_cnt_adv;
        bit_idx_d = bit_idx_adv;
        if (byte_end) begin
          state_d    = S_WORD;
          byte_idx_d = '0;
          word_idx_d = '0;
        end
      end

      S_WORD: begin
        bit_cnt_d = bit_cnt_adv;
        bit_idx_d = bit_idx_adv;
        if (byte_end) begin
          byte_idx_d = (byte_idx_q == BYTE_IDX_LAST) ? 2'd0 : byte_idx_q + 2'd1;
        end
        if (word_end) begin
          if (word_idx_q == WORD_IDX_LAST) begin
            state_d    = S_DONE;
            word_idx_d = '0;
          end else begin
            word_idx_d = word_idx_q + 7'd1;
            // The address being sampled was set a full word earlier.
            if (word_idx_q <= LAST_PRE_RF) begin
              word_buf_d = rf_data;
              rf_addr_d  = (rf_addr_q == IDX_LAST) ? 5'd0 : rf_addr_q + 5'd1;
            end else begin
              word_buf_d = mem_data;
              mem_idx_d  = (mem_idx_q == IDX_LAST) ? 5'd0 : mem_idx_q + 5'd1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the next cycle, derived from next-state so tx is a clean flop output.
  always_comb begin
    cur_byte = (state_d == S_HDR) ? HEADER : word_byte(word_buf_d, byte_idx_d);
    data_sel = 3'(bit_idx_d - 4'd1);
    tx_d     = 1'b1;
    if (state_d == S_HDR || state_d == S_WORD) begin
      if (bit_idx_d == 4'd0) begin
        tx_d = 1'b0;
      end else if (bit_idx_d == BIT_IDX_LAST) begin
        tx_d = 1'b1;
      end else begin
        tx_d = cur_byte[data_sel];
      end
    end
  end

  // State register with synchronous active-low reset; reset wins over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      word_buf_q <= '0;
      rf_addr_q  <= '0;
      mem_idx_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      word_buf_q <= word_buf_d;
      rf_addr_q  <= rf_addr_d;
      mem_idx_q  <= mem_idx_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q == S_HDR) || (state_q == S_WORD);
  assign done     = (state_q == S_DONE);
  assign rf_addr  = rf_addr_q;
  assign mem_addr = {25'd0, mem_idx_q, 2'b00};

endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb_cpu_state_dumper
// Drives cpu_state_dumper with a behavioural CPU display model (register file
// and data memory arrays) and checks the UART line against a frame built from
// the CPU state snapshot.
module tb_cpu_state_dumper;

  localparam int CPB         = 4;
  localparam int FRAME_BYTES = 261;
  localparam int T           = 2610 * CPB;   // start edge to done edge
  localparam int MAXS        = T + 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] cpu_pc;
  logic [31:0] rf_data;
  logic [31:0] mem_data;
  logic [4:0]  rf_addr;
  logic [31:0] mem_addr;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] rf  [32];
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int frame_cycle;

  logic        tx_s   [MAXS];
  logic        busy_s [MAXS];
  logic        done_s [MAXS];
  logic [4:0]  rf_at_end;
  logic [31:0] mem_at_end;
  logic [31:0] pc_snap;
  logic [7:0]  exp_b  [FRAME_BYTES];
  logic [7:0]  dec_b  [FRAME_BYTES];
  logic [7:0]  prev_b [FRAME_BYTES];

  cpu_state_dumper #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .cpu_pc   (cpu_pc),
    .rf_data  (rf_data),
    .mem_data (mem_data),
    .rf_addr  (rf_addr),
    .mem_addr (mem_addr),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // CPU display model: combinational reads; misaligned or out-of-range addresses return a marker.
  always_comb begin
    rf_data = rf[rf_addr];
    if (mem_addr[31:7] == 25'd0 && mem_addr[1:0] == 2'b00) mem_data = mem[mem_addr[6:2]];
    else                                                   mem_data = 32'hBAD0_0000 ^ mem_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic randomize_cpu();
    for (int i = 0; i < 32; i++) begin
      rf[i]  = $urandom;
      mem[i] = $urandom;
    end
    rf[0]  = 32'd0;
    cpu_pc = $urandom;
  endtask

  // Expected frame: header, PC, r0..r31, mem[0..31], each word MSB first.
  task automatic build_expected();
    logic [31:0] w;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 65; k++) begin
      if (k == 0)       w = pc_snap;
      else if (k <= 32) w = rf[k-1];
      else              w = mem[k-33];
      exp_b[1+4*k] = w[31:24];
      exp_b[2+4*k] = w[23:16];
      exp_b[3+4*k] = w[15:8];
      exp_b[4+4*k] = w[7:0];
    end
  endtask

  function automatic logic exp_tx(input int t);
    int b;
    int i;
    logic [7:0] eb;
    b = t / (10 * CPB);
    i = (t / CPB) % 10;
    eb = exp_b[b];
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return eb[i-1];
  endfunction

  // Pulses start at the current negedge, then records the line from the start edge
  // (offset 0) through the done edge (offset T) plus 'post' cycles. inj* offsets
  // raise start for the edge after that sample.
  task automatic capture_frame(input int inj0, input int inj1, input int inj2, input int post);
    pc_snap = cpu_pc;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_pc      = ~pc_snap;
    frame_cycle = cycle;
    for (int t = 0; t <= T + post; t++) begin
      if (t > 0) @(negedge clk);
      tx_s[t]   = tx;
      busy_s[t] = busy;
      done_s[t] = done;
      if (t == T) begin
        rf_at_end  = rf_addr;
        mem_at_end = mem_addr;
      end
      start = (t == inj0 || t == inj1 || t == inj2);
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string name, input int post);
    int   bad;
    int   first;
    logic fgot;
    logic fwant;
    logic [7:0] d;
    build_expected();

    bad = 0; first = -1; fgot = 1'b0; fwant = 1'b0;
    for (int t = 0; t < T; t++) begin
      if (tx_s[t] !== exp_tx(t)) begin
        if (first < 0) begin first = t; fgot = tx_s[t]; fwant = exp_tx(t); end
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s tx_bitstream: %0d wrong cycles, first at offset %0d got %b want %b", name, bad, first, fgot, fwant);
    end

    for (int b = 0; b < FRAME_BYTES; b++) begin
      for (int i = 0; i < 8; i++) d[i] = tx_s[b*10*CPB + (i+1)*CPB + CPB/2];
      dec_b[b] = d;
    end
    bad = 0; first = -1;
    for (int b = 0; b < FRAME_BYTES; b++) begin
      if (dec_b[b] !== exp_b[b]) begin
        if (first < 0) first = b;
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s decoded_bytes: %0d wrong, first byte %0d got %02h want %02h", name, bad, first, dec_b[first], exp_b[first]);
    end

    bad = 0;
    for (int t = 0; t < T; t++) if (busy_s[t] !== 1'b1 || done_s[t] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_done_in_frame: %0d cycles wrong, want busy=1 done=0", name, bad);
    end

    n_checks++;
    if (done_s[T] !== 1'b1 || busy_s[T] !== 1'b0 || tx_s[T] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end_edge: got done=%b busy=%b tx=%b want done=1 busy=0 tx=1", name, done_s[T], busy_s[T], tx_s[T]);
    end

    n_checks++;
    if (rf_at_end !== 5'd0 || mem_at_end !== 32'd0) begin
      n_fail++;
      $display("FAIL %s end_addrs: got rf_addr=%0d mem_addr=%h want 0 and 0", name, rf_at_end, mem_at_end);
    end

    bad = 0;
    for (int t = T + 1; t <= T + post; t++) if (done_s[t] !== 1'b0 || busy_s[t] !== 1'b0 || tx_s[t] !== 1'b1) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s after_done: %0d cycles wrong, want done=0 busy=0 tx=1", name, bad);
    end
  endtask

  task automatic test_reset();
    int bad;
    resetn = 1'b0;
    start  = 1'b1;
    randomize_cpu();
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_addr !== 5'd0 || mem_addr !== 32'd0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d cycles wrong, last tx=%b busy=%b done=%b rf_addr=%0d mem_addr=%h, want 1 0 0 0 0", bad, tx, busy, done, rf_addr, mem_addr);
    end
    resetn = 1'b1;
    start  = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_frame: %0d idle cycles wrong, last tx=%b busy=%b, want tx=1 busy=0", bad, tx, busy);
    end
  endtask

  task automatic test_header_timing();
    int bad;
    logic [7:0] hdr;
    randomize_cpu();
    capture_frame(-1, -1, -1, 4);
    hdr = 8'hA5;

    bad = 0;
    for (int t = 0; t < CPB; t++) if (tx_s[t] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hdr_start_bit: %0d of %0d cycles high, want all low", bad, CPB);
    end

    bad = 0;
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++)
        if (tx_s[CPB*(i+1) + c] !== hdr[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hdr_data_bits: %0d cycles wrong, want 1,0,1,0,0,1,0,1 each %0d cycles", bad, CPB);
    end

    bad = 0;
    for (int t = 9*CPB; t < 10*CPB; t++) if (tx_s[t] !== 1'b1) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hdr_stop_bit: %0d of %0d cycles low, want all high", bad, CPB);
    end

    check_frame("header_frame", 4);
  endtask

  task automatic test_full_frame();
    randomize_cpu();
    cpu_pc  = 32'h0000_0040;
    rf[1]   = 32'h1234_5678;
    rf[31]  = 32'hDEAD_BEEF;
    mem[31] = 32'hCAFE_F00D;
    capture_frame(-1, -1, -1, 4);
    check_frame("full_frame", 4);

    n_checks++;
    if ({dec_b[1], dec_b[2], dec_b[3], dec_b[4]} !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL full_pc_bytes: got %02h %02h %02h %02h want 00 00 00 40", dec_b[1], dec_b[2], dec_b[3], dec_b[4]);
    end
    n_checks++;
    if ({dec_b[9], dec_b[10], dec_b[11], dec_b[12]} !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL full_r1_bytes: got %02h %02h %02h %02h want 12 34 56 78", dec_b[9], dec_b[10], dec_b[11], dec_b[12]);
    end
    n_checks++;
    if ({dec_b[129], dec_b[130], dec_b[131], dec_b[132]} !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL full_r31_bytes: got %02h %02h %02h %02h want DE AD BE EF", dec_b[129], dec_b[130], dec_b[131], dec_b[132]);
    end
    n_checks++;
    if ({dec_b[257], dec_b[258], dec_b[259], dec_b[260]} !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL full_mem31_bytes: got %02h %02h %02h %02h want CA FE F0 0D", dec_b[257], dec_b[258], dec_b[259], dec_b[260]);
    end
    n_checks++;
    if (done_s[10440] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_done_time: done at offset 10440 got %b want 1", done_s[10440]);
    end
  endtask

  task automatic test_start_while_busy();
    int pulses;
    randomize_cpu();
    // start seen at edges N+100 and N+5000 (busy), and in the DONE cycle
    capture_frame(99, 4999, T, 20);
    check_frame("start_while_busy", 20);
    pulses = 0;
    for (int t = 0; t <= T + 20; t++) if (done_s[t] === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL busy_done_count: got %0d done pulses want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    randomize_cpu();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (1999) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got busy=%b want 1", busy);
    end
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
    n_checks++;
    if (rf_addr !== 5'd0 || mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_addrs: got rf_addr=%0d mem_addr=%h want 0 0", rf_addr, mem_addr);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    start  = 1'b0;
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_idle_after: %0d cycles wrong, want tx=1 busy=0", bad);
    end
    randomize_cpu();
    capture_frame(-1, -1, -1, 4);
    check_frame("after_abort", 4);
  endtask

  task automatic test_back_to_back();
    int          first_cycle;
    logic [31:0] pc1;
    int          bad;
    randomize_cpu();
    pc1 = cpu_pc;
    capture_frame(-1, -1, -1, 1);
    check_frame("b2b_first", 1);
    first_cycle = frame_cycle;
    for (int b = 0; b < FRAME_BYTES; b++) prev_b[b] = dec_b[b];

    cpu_pc = pc1;
    capture_frame(-1, -1, -1, 4);
    check_frame("b2b_second", 4);
    n_checks++;
    if (frame_cycle - first_cycle != T + 2) begin
      n_fail++;
      $display("FAIL b2b_gap: second start %0d cycles after first, want %0d", frame_cycle - first_cycle, T + 2);
    end
    bad = 0;
    for (int b = 0; b < FRAME_BYTES; b++) if (dec_b[b] !== prev_b[b]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_identical: %0d bytes differ between frames, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_header_timing();
    test_full_frame();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
